video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_pkg.sv | 60 ++++++
 rtl/video_timing_gen_if.sv | 31 +++
 rtl/video_timing_gen_raster_counter.sv | 50 +++++
 rtl/video_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared timing presets (720p, 480p), derived totals and small helpers for video_timing_gen.
package video_timing_gen_pkg;

  localparam int DEFAULT_COUNT_BITS = 12;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } timing_t;

  localparam timing_t TIMING_720P = '{h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
                                      v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
                                      hs_pol: 1'b1, vs_pol: 1'b1};

  localparam timing_t TIMING_480P = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                      v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                      hs_pol: 1'b0, vs_pol: 1'b0};

  function automatic int h_total_of(timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total_of(timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  localparam int T720_H_TOTAL = h_total_of(TIMING_720P);
  localparam int T720_V_TOTAL = v_total_of(TIMING_720P);
  localparam int T480_H_TOTAL = h_total_of(TIMING_480P);
  localparam int T480_V_TOTAL = v_total_of(TIMING_480P);

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FP,
    SEG_SYNC,
    SEG_BP
  } segment_t;

  // Lines and frames are laid out active, front porch, sync, back porch.
  function automatic segment_t segment_of(int pos, int active, int fp, int sync);
    if (pos < active)                  return SEG_ACTIVE;
    else if (pos < active + fp)        return SEG_FP;
    else if (pos < active + fp + sync) return SEG_SYNC;
    else                               return SEG_BP;
  endfunction

  // First column of colour bar k; floor(x*8/h_active) >= k exactly when x >= this value.
  function automatic int bar_threshold(int k, int h_active);
    return (k * h_active + 7) / 8;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Signal bundle between video_timing_gen (master) and its pixel/colour consumer (slave).
interface video_timing_gen_if
  import video_timing_gen_pkg::*;
#(
  parameter int COUNT_BITS = DEFAULT_COUNT_BITS
);
  logic                  en;
  logic                  hs;
  logic                  vs;
  logic                  de;
  logic [COUNT_BITS-1:0] x;
  logic [COUNT_BITS-1:0] y;
  logic                  frame_start;
  logic                  fetch_valid;
  logic [COUNT_BITS-1:0] fetch_x;
  logic [COUNT_BITS-1:0] fetch_y;
  logic                  r;
  logic                  g;
  logic                  b;

  modport master (
    input  en,
    output hs, vs, de, x, y, frame_start, fetch_valid, fetch_x, fetch_y, r, g, b
  );

  modport slave (
    output en,
    input  hs, vs, de, x, y, frame_start, fetch_valid, fetch_x, fetch_y, r, g, b
  );

endinterface

// File: rtl/video_timing_gen_raster_counter.sv
// Horizontal/vertical raster counter pair; advances only when en is high.
module video_timing_gen_raster_counter
  import video_timing_gen_pkg::*;
#(
  parameter int COUNT_BITS = DEFAULT_COUNT_BITS,
  parameter int H_TOTAL    = T720_H_TOTAL,
  parameter int V_TOTAL    = T720_V_TOTAL,
  parameter int H_INIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic [COUNT_BITS-1:0] hc,
  output logic [COUNT_BITS-1:0] vc
);

  localparam logic [COUNT_BITS-1:0] H_LAST  = COUNT_BITS'(H_TOTAL - 1);
  localparam logic [COUNT_BITS-1:0] V_LAST  = COUNT_BITS'(V_TOTAL - 1);
  localparam logic [COUNT_BITS-1:0] H_START = COUNT_BITS'(H_INIT);

  logic [COUNT_BITS-1:0] hc_d, hc_q;
  logic [COUNT_BITS-1:0] vc_d, vc_q;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q <= H_START;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc = hc_q;
  assign vc = vc_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: display raster plus a fetch raster running FETCH_LEAD cycles ahead.
// Define VIDEO_TIMING_COLOR_BAR_EN to drive 8 vertical test-pattern bars on r/g/b.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = TIMING_720P.h_active,
  parameter int H_FP       = TIMING_720P.h_fp,
  parameter int H_SYNC     = TIMING_720P.h_sync,
  parameter int H_BP       = TIMING_720P.h_bp,
  parameter int V_ACTIVE   = TIMING_720P.v_active,
  parameter int V_FP       = TIMING_720P.v_fp,
  parameter int V_SYNC     = TIMING_720P.v_sync,
  parameter int V_BP       = TIMING_720P.v_bp,
  parameter bit HS_POL     = TIMING_720P.hs_pol,
  parameter bit VS_POL     = TIMING_720P.vs_pol,
  parameter int FETCH_LEAD = 2,
  parameter int COUNT_BITS = DEFAULT_COUNT_BITS
) (
  input logic                clk,
  input logic                reset,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [COUNT_BITS-1:0] hc, vc, fhc, fvc;
  segment_t              h_seg, v_seg, fh_seg, fv_seg;
  logic                  disp_active, fetch_active;

  logic                  hs_d, hs_q;
  logic                  vs_d, vs_q;
  logic                  de_d, de_q;
  logic                  frame_start_d, frame_start_q;
  logic                  fetch_valid_d, fetch_valid_q;
  logic [COUNT_BITS-1:0] x_d, x_q;
  logic [COUNT_BITS-1:0] y_d, y_q;
  logic [COUNT_BITS-1:0] fetch_x_d, fetch_x_q;
  logic [COUNT_BITS-1:0] fetch_y_d, fetch_y_q;

  video_timing_gen_raster_counter #(
    .COUNT_BITS (COUNT_BITS),
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .H_INIT     (0)
  ) u_display (
    .clk   (clk),
    .reset (reset),
    .en    (vif.en),
    .hc    (hc),
    .vc    (vc)
  );

  // Same raster started FETCH_LEAD columns in, so it stays that many en-cycles ahead forever.
  video_timing_gen_raster_counter #(
    .COUNT_BITS (COUNT_BITS),
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .H_INIT     (FETCH_LEAD)
  ) u_fetch (
    .clk   (clk),
    .reset (reset),
    .en    (vif.en),
    .hc    (fhc),
    .vc    (fvc)
  );

  assign h_seg  = segment_of(int'(hc),  H_ACTIVE, H_FP, H_SYNC);
  assign v_seg  = segment_of(int'(vc),  V_ACTIVE, V_FP, V_SYNC);
  assign fh_seg = segment_of(int'(fhc), H_ACTIVE, H_FP, H_SYNC);
  assign fv_seg = segment_of(int'(fvc), V_ACTIVE, V_FP, V_SYNC);

  assign disp_active  = (h_seg  == SEG_ACTIVE) && (v_seg  == SEG_ACTIVE);
  assign fetch_active = (fh_seg == SEG_ACTIVE) && (fv_seg == SEG_ACTIVE);

  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    fetch_valid_d = fetch_valid_q;
    fetch_x_d     = fetch_x_q;
    fetch_y_d     = fetch_y_q;
    frame_start_d = 1'b0;
    if (vif.en) begin
      hs_d          = (h_seg == SEG_SYNC) ? HS_POL : ~HS_POL;
      vs_d          = (v_seg == SEG_SYNC) ? VS_POL : ~VS_POL;
      de_d          = disp_active;
      x_d           = disp_active ? hc : '0;
      y_d           = disp_active ? vc : '0;
      frame_start_d = (hc == '0) && (vc == '0);
      fetch_valid_d = fetch_active;
      fetch_x_d     = fetch_active ? fhc : '0;
      fetch_y_d     = fetch_active ? fvc : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
    end
  end

`ifdef VIDEO_TIMING_COLOR_BAR_EN
  logic [2:0] bar_idx;
  logic [2:0] rgb_d, rgb_q;

  // Count how many constant bar boundaries hc has passed; avoids a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(hc) >= bar_threshold(k, H_ACTIVE)) bar_idx = 3'(k);
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    if (vif.en) rgb_d = disp_active ? bar_idx : 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= 3'd0;
    else       rgb_q <= rgb_d;
  end

  assign vif.r = rgb_q[2];
  assign vif.g = rgb_q[1];
  assign vif.b = rgb_q[0];
`else
  assign vif.r = 1'b0;
  assign vif.g = 1'b0;
  assign vif.b = 1'b0;
`endif

  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.de          = de_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = frame_start_q;
  assign vif.fetch_valid = fetch_valid_q;
  assign vif.fetch_x     = fetch_x_q;
  assign vif.fetch_y     = fetch_y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: small rasters (fetch lead 0 and 3) plus the default 720p build.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        fv;
    logic [11:0] fx;
    logic [11:0] fy;
    logic [2:0]  rgb;
  } vid_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lead;
  } cfg_t;

  typedef struct packed {
    logic        en;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        fs;
  } vec_t;

`ifdef VIDEO_TIMING_COLOR_BAR_EN
  localparam logic [2:0] BAR_AT_160  = 3'b001;
  localparam logic [2:0] BAR_AT_1279 = 3'b111;
`else
  localparam logic [2:0] BAR_AT_160  = 3'b000;
  localparam logic [2:0] BAR_AT_1279 = 3'b000;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_evt   = 0;
  bit   last_en = 1'b0;

  cfg_t cfg_a, cfg_b, cfg_c;
  vid_t act_a, act_b, act_c;
  vec_t tbl [17];
  logic [24:0] fq [$];

  always #5 clk = ~clk;

  video_timing_gen_if #(.COUNT_BITS(12)) vif_a ();
  video_timing_gen_if #(.COUNT_BITS(12)) vif_b ();
  video_timing_gen_if #(.COUNT_BITS(12)) vif_c ();

  assign vif_a.en = en;
  assign vif_b.en = en;
  assign vif_c.en = en;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LEAD(0), .COUNT_BITS(12)
  ) dut_a (.clk(clk), .reset(reset), .vif(vif_a));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LEAD(3), .COUNT_BITS(12)
  ) dut_b (.clk(clk), .reset(reset), .vif(vif_b));

  video_timing_gen dut_c (.clk(clk), .reset(reset), .vif(vif_c));

  assign act_a = {vif_a.hs, vif_a.vs, vif_a.de, vif_a.x, vif_a.y, vif_a.frame_start,
                  vif_a.fetch_valid, vif_a.fetch_x, vif_a.fetch_y, vif_a.r, vif_a.g, vif_a.b};
  assign act_b = {vif_b.hs, vif_b.vs, vif_b.de, vif_b.x, vif_b.y, vif_b.frame_start,
                  vif_b.fetch_valid, vif_b.fetch_x, vif_b.fetch_y, vif_b.r, vif_b.g, vif_b.b};
  assign act_c = {vif_c.hs, vif_c.vs, vif_c.de, vif_c.x, vif_c.y, vif_c.frame_start,
                  vif_c.fetch_valid, vif_c.fetch_x, vif_c.fetch_y, vif_c.r, vif_c.g, vif_c.b};

  // n_evt counts enabled clock edges since reset; last_en remembers whether the latest edge was enabled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n_evt   <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= en;
      if (en) n_evt <= n_evt + 1;
    end
  end

  // Expected outputs after n enabled edges: the raster position shown is (n-1) mod frame length.
  function automatic vid_t model_out(cfg_t c, int n, bit le);
    vid_t o;
    int   ht, vt, frame, p, h, v, q, fh, fvv;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    frame = ht * vt;
    o     = '0;
    if (n == 0) return o;
    p    = (n - 1) % frame;
    h    = p % ht;
    v    = p / ht;
    o.de = (h < c.ha) && (v < c.va);
    o.x  = o.de ? 12'(h) : 12'd0;
    o.y  = o.de ? 12'(v) : 12'd0;
    o.hs = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    o.vs = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    o.fs = le && (p == 0);
    q    = (n - 1 + c.lead) % frame;
    fh   = q % ht;
    fvv  = q / ht;
    o.fv = (fh < c.ha) && (fvv < c.va);
    o.fx = o.fv ? 12'(fh) : 12'd0;
    o.fy = o.fv ? 12'(fvv) : 12'd0;
`ifdef VIDEO_TIMING_COLOR_BAR_EN
    if (o.de) o.rgb = 3'((h * 8) / c.ha);
`endif
    return o;
  endfunction

  function automatic vec_t mk_vec(logic e, logic d, int x, int y, logic h, logic f);
    return {e, d, 12'(x), 12'(y), h, f};
  endfunction

  task automatic compare_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: target not seen within cycle budget (seen 0, required 1)", name);
  endtask

  task automatic applyStimulus(input logic en_val);
    en = en_val;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    compare_vec({tag, " A"}, 64'(act_a), 64'(model_out(cfg_a, n_evt, last_en)));
    compare_vec({tag, " B"}, 64'(act_b), 64'(model_out(cfg_b, n_evt, last_en)));
    compare_vec({tag, " C"}, 64'(act_c), 64'(model_out(cfg_c, n_evt, last_en)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int fs_count, first_fs, period;
    bit found;

    cfg_a = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, lead: 0};
    cfg_b = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, lead: 3};
    cfg_c = '{ha: 1280, hf: 110, hs: 40, hb: 220, va: 720, vf: 5, vs: 5, vb: 20, lead: 2};

    tbl[0]  = mk_vec(1, 1, 0, 0, 0, 1);
    tbl[1]  = mk_vec(1, 1, 1, 0, 0, 0);
    tbl[2]  = mk_vec(0, 1, 1, 0, 0, 0);
    tbl[3]  = mk_vec(1, 1, 2, 0, 0, 0);
    tbl[4]  = mk_vec(1, 1, 3, 0, 0, 0);
    tbl[5]  = mk_vec(1, 1, 4, 0, 0, 0);
    tbl[6]  = mk_vec(1, 1, 5, 0, 0, 0);
    tbl[7]  = mk_vec(1, 1, 6, 0, 0, 0);
    tbl[8]  = mk_vec(1, 1, 7, 0, 0, 0);
    tbl[9]  = mk_vec(1, 0, 0, 0, 0, 0);
    tbl[10] = mk_vec(1, 0, 0, 0, 0, 0);
    tbl[11] = mk_vec(1, 0, 0, 0, 1, 0);
    tbl[12] = mk_vec(0, 0, 0, 0, 1, 0);
    tbl[13] = mk_vec(1, 0, 0, 0, 1, 0);
    tbl[14] = mk_vec(1, 0, 0, 0, 0, 0);
    tbl[15] = mk_vec(1, 0, 0, 0, 0, 0);
    tbl[16] = mk_vec(1, 1, 0, 1, 0, 0);

    $display("[TB] presets: 720p total %0dx%0d, 480p total %0dx%0d",
             T720_H_TOTAL, T720_V_TOTAL, T480_H_TOTAL, T480_V_TOTAL);

    // Reset state, then the first line of the small raster against hand-derived vectors.
    do_reset();
    checkOutput("reset");
    compare_vec("reset A zero", 64'(act_a), 64'd0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].en);
      checkOutput("table");
      compare_vec($sformatf("table row %0d", i),
                  64'({vif_a.de, vif_a.x, vif_a.y, vif_a.hs, vif_a.frame_start}),
                  64'({tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].fs}));
    end

    // Two full frames with en held high: frame_start cadence and fetch lead of 3.
    do_reset();
    fs_count = 0;
    first_fs = -1;
    period   = -1;
    fq.delete();
    for (int i = 1; i <= 196; i++) begin
      applyStimulus(1'b1);
      checkOutput("frames");
      if (vif_a.frame_start) begin
        fs_count++;
        compare_vec("fs at origin", 64'({vif_a.de, vif_a.x, vif_a.y}), 64'({1'b1, 24'd0}));
        if (first_fs < 0) first_fs = i;
        else              period   = i - first_fs;
      end
      fq.push_back({vif_b.fetch_valid, vif_b.fetch_x, vif_b.fetch_y});
      if (fq.size() > 3)
        compare_vec("fetch lead 3", 64'(fq.pop_front()), 64'({vif_b.de, vif_b.x, vif_b.y}));
    end
    compare_vec("fs count", 64'(fs_count), 64'd2);
    compare_vec("frame period", 64'(period), 64'd98);

    // en dropped for 5 cycles at x=4, y=2.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1'b1);
      checkOutput("seek hold");
      if (vif_a.de && vif_a.x == 12'd4 && vif_a.y == 12'd2) found = 1'b1;
    end
    if (!found) bound_fail("seek x4 y2");
    else begin
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0);
        checkOutput("hold");
        compare_vec("hold A",
                    64'({vif_a.de, vif_a.x, vif_a.y, vif_a.hs, vif_a.vs, vif_a.frame_start}),
                    64'({1'b1, 12'd4, 12'd2, 3'b000}));
        compare_vec("hold B fetch",
                    64'({vif_b.fetch_valid, vif_b.fetch_x, vif_b.fetch_y}),
                    64'({1'b1, 12'd7, 12'd2}));
      end
      applyStimulus(1'b1);
      checkOutput("resume");
      compare_vec("resume A", 64'({vif_a.de, vif_a.x, vif_a.y, vif_a.frame_start}),
                  64'({1'b1, 12'd5, 12'd2, 1'b0}));
    end

    // Asynchronous reset at x=6, y=3, then restart at the origin.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1'b1);
      checkOutput("seek reset");
      if (vif_a.de && vif_a.x == 12'd6 && vif_a.y == 12'd3) found = 1'b1;
    end
    if (!found) bound_fail("seek x6 y3");
    else begin
      #2 reset = 1'b1;
      #1;
      compare_vec("async reset A", 64'(act_a), 64'd0);
      compare_vec("async reset B", 64'(act_b), 64'd0);
      compare_vec("async reset C", 64'(act_c), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("post reset");
      applyStimulus(1'b1);
      checkOutput("restart");
      compare_vec("restart A", 64'({vif_a.de, vif_a.x, vif_a.y, vif_a.frame_start}),
                  64'({1'b1, 24'd0, 1'b1}));
    end

    // First 720p line: colour bar boundaries on the default build.
    do_reset();
    for (int i = 1; i <= 1281; i++) begin
      applyStimulus(1'b1);
      checkOutput("bars");
      if (i == 1)
        compare_vec("bar x0", 64'({vif_c.de, vif_c.x, vif_c.r, vif_c.g, vif_c.b}),
                    64'({1'b1, 12'd0, 3'b000}));
      if (i == 161)
        compare_vec("bar x160", 64'({vif_c.de, vif_c.x, vif_c.r, vif_c.g, vif_c.b}),
                    64'({1'b1, 12'd160, BAR_AT_160}));
      if (i == 1280)
        compare_vec("bar x1279", 64'({vif_c.de, vif_c.x, vif_c.r, vif_c.g, vif_c.b}),
                    64'({1'b1, 12'd1279, BAR_AT_1279}));
      if (i == 1281)
        compare_vec("bar blank", 64'({vif_c.de, vif_c.x, vif_c.r, vif_c.g, vif_c.b}),
                    64'({1'b0, 12'd0, 3'b000}));
    end

    // Random enable pattern with occasional resets against the reference model.
    do_reset();
    checkOutput("rand reset");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        checkOutput("rand reset");
      end
      applyStimulus($urandom_range(0, 3) != 0);
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
